// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the core's unified instruction/data memory: port 0 is the CPU, port 1 the debug loader.
// Define MEM_ARB_CPU_PRIORITY_EN for fixed port-0 priority on ties; the default build arbitrates round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, CMD, RWAIT} state_t;

    // RD_LAT is limited to 1..4, so the wait counter never needs more than two bits.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t     state;
    logic       last_gnt;
    logic       cur_port;
    logic [1:0] cnt;
    logic       tie_pick;
    logic       pick;

    always_comb begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
        tie_pick = 1'b0;
`else
        tie_pick = ~last_gnt;
`endif
        pick = (req0 && req1) ? tie_pick : req1;
    end

    // mem_we/mem_adr/mem_wd double as the latched transaction, so CMD issues straight from them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            cur_port <= 1'b0;
            cnt      <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_adr  <= '0;
            mem_wd   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout: every branch sees pre-edge values (CMD reads the
            // mem_we it issued with), and the strobe defaults below make each asserting branch a 1-cycle pulse.
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state    <= CMD;
                        busy     <= 1'b1;
                        cur_port <= pick;
                        last_gnt <= pick;
                        gnt0     <= ~pick;
                        gnt1     <= pick;
                        mem_en   <= 1'b1;
                        mem_we   <= pick ? we1 : we0;
                        mem_adr  <= pick ? adr1 : adr0;
                        mem_wd   <= pick ? wd1 : wd0;
                    end
                end
                CMD: begin
                    if (mem_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RWAIT;
                        cnt   <= LAT_LOAD;
                    end
                end
                RWAIT: begin
                    if (cnt == 2'd0) begin
                        rdata   <= mem_rd;
                        rvalid0 <= ~cur_port;
                        rvalid1 <= cur_port;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RD_LAT 1, 2, 4) each with a latency-accurate memory model;
// only the instance picked by sel sees requests, and expected grants/read data are queued as stimulus is driven.
module tb_mem_port_arbiter;

    localparam int N = 3;

    function automatic int lat_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] init_word(int i);
        if (i == 8) return 32'hDEADBEEF;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] adr0, adr1, wd0, wd1;
    int          sel;

    logic        gnt0_v [N];
    logic        gnt1_v [N];
    logic        rv0_v  [N];
    logic        rv1_v  [N];
    logic        busy_v [N];
    logic        en_v   [N];
    logic        we_v   [N];
    logic [31:0] rdata_v [N];
    logic [31:0] madr_v  [N];
    logic [31:0] mwd_v   [N];
    logic [31:0] mrd_v   [N];

    logic        s_gnt0, s_gnt1, s_rv0, s_rv1, s_busy, s_en, s_we;
    logic [31:0] s_rdata, s_adr, s_wd;

    logic [31:0] ref_mem [64];
    rd_exp_t     rd_q [$];
    logic        gnt_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        localparam int L = lat_of(g);
        logic [31:0] mem  [64];
        logic [31:0] pipe [L];

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(L)) dut (
            .clk     (clk),
            .reset   (reset),
            .req0    (req0 && (sel == g)),
            .req1    (req1 && (sel == g)),
            .we0     (we0),
            .we1     (we1),
            .adr0    (adr0),
            .adr1    (adr1),
            .wd0     (wd0),
            .wd1     (wd1),
            .gnt0    (gnt0_v[g]),
            .gnt1    (gnt1_v[g]),
            .rvalid0 (rv0_v[g]),
            .rvalid1 (rv1_v[g]),
            .rdata   (rdata_v[g]),
            .busy    (busy_v[g]),
            .mem_en  (en_v[g]),
            .mem_we  (we_v[g]),
            .mem_adr (madr_v[g]),
            .mem_wd  (mwd_v[g]),
            .mem_rd  (mrd_v[g])
        );

        // Read data is only meaningful exactly L cycles after the command; any other cycle shows a marker.
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            end else if (en_v[g] && we_v[g]) begin
                mem[madr_v[g][7:2]] <= mwd_v[g];
            end
            pipe[0] <= (en_v[g] && !we_v[g]) ? mem[madr_v[g][7:2]] : 32'hBAD0_BAD0;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mrd_v[g] = pipe[L-1];
    end

    always_comb begin
        s_gnt0  = gnt0_v[sel];
        s_gnt1  = gnt1_v[sel];
        s_rv0   = rv0_v[sel];
        s_rv1   = rv1_v[sel];
        s_busy  = busy_v[sel];
        s_en    = en_v[sel];
        s_we    = we_v[sel];
        s_rdata = rdata_v[sel];
        s_adr   = madr_v[sel];
        s_wd    = mwd_v[sel];
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        int rv_seen;
        sel = 1;
        do_reset();
        vectors++;
        if ({s_gnt0, s_gnt1, s_rv0, s_rv1, s_busy, s_en, s_we, s_rdata, s_adr, s_wd} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got ctl=%b rdata=%h adr=%h wd=%h expected all zero",
                     {s_gnt0, s_gnt1, s_rv0, s_rv1, s_busy, s_en, s_we}, s_rdata, s_adr, s_wd);
        end
        adr0 = 32'h10; we0 = 1'b0; req0 = 1'b1;
        step();
        vectors++;
        if ({s_gnt0, s_en, s_adr} !== {1'b1, 1'b1, 32'h10}) begin
            miscompares++;
            $display("FAIL reset_rd_gnt: got gnt0=%b en=%b adr=%h expected 1 1 00000010", s_gnt0, s_en, s_adr);
        end
        req0 = 1'b0;
        step();
        vectors++;
        if (s_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rd_busy: got %b expected 1", s_busy);
        end
        reset = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        #1;
        vectors++;
        if ({s_gnt0, s_gnt1, s_rv0, s_rv1, s_busy, s_en, s_we, s_rdata, s_adr, s_wd} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_read: got ctl=%b rdata=%h adr=%h wd=%h expected all zero",
                     {s_gnt0, s_gnt1, s_rv0, s_rv1, s_busy, s_en, s_we}, s_rdata, s_adr, s_wd);
        end
        step();
        reset = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            rv_seen += int'(s_rv0) + int'(s_rv1) + int'(s_busy);
        end
        vectors++;
        if (rv_seen !== 0) begin
            miscompares++;
            $display("FAIL reset_drop_read: got %0d rvalid/busy cycles expected 0", rv_seen);
        end
    endtask

    task automatic test_single_read();
        int      got;
        rd_exp_t e;
        sel = 1;
        rd_q.push_back('{port: 1'b0, data: ref_mem[8]});
        adr0 = 32'h20; we0 = 1'b0; req0 = 1'b1;
        step();
        vectors++;
        if ({s_gnt0, s_gnt1, s_en, s_we, s_busy, s_adr} !== {5'b10101, 32'h20}) begin
            miscompares++;
            $display("FAIL read_cmd: got gnt0/gnt1/en/we/busy=%b adr=%h expected 10101 00000020",
                     {s_gnt0, s_gnt1, s_en, s_we, s_busy}, s_adr);
        end
        req0 = 1'b0;
        got = -1;
        for (int k = 2; k <= 10 && got < 0; k++) begin
            step();
            if (s_rv0 || s_rv1) begin
                got = k;
                e = rd_q.pop_front();
                vectors++;
                if ({s_rv1, s_busy, s_rdata} !== {e.port, 1'b0, e.data}) begin
                    miscompares++;
                    $display("FAIL read_data: got port=%b busy=%b rdata=%h expected %b 0 %h",
                             s_rv1, s_busy, s_rdata, e.port, e.data);
                end
            end
        end
        vectors++;
        if (got !== 4) begin
            miscompares++;
            $display("FAIL read_latency: got rvalid at T+%0d expected T+4", got);
        end
        step();
        vectors++;
        if ({s_rv0, s_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL read_hold: got rv0=%b rdata=%h expected 0 deadbeef", s_rv0, s_rdata);
        end
    endtask

    task automatic test_single_write();
        int rv_seen;
        sel = 1;
        adr1 = 32'h40; wd1 = 32'h12345678; we1 = 1'b1; req1 = 1'b1;
        ref_mem[16] = 32'h12345678;
        step();
        vectors++;
        if ({s_gnt0, s_gnt1, s_en, s_we, s_adr, s_wd} !== {4'b0111, 32'h40, 32'h12345678}) begin
            miscompares++;
            $display("FAIL write_cmd: got gnt0/gnt1/en/we=%b adr=%h wd=%h expected 0111 00000040 12345678",
                     {s_gnt0, s_gnt1, s_en, s_we}, s_adr, s_wd);
        end
        req1 = 1'b0; we1 = 1'b0;
        step();
        vectors++;
        if ({s_busy, s_gnt1, s_en, s_we, s_adr} !== {4'b0000, 32'h40}) begin
            miscompares++;
            $display("FAIL write_done: got busy/gnt1/en/we=%b adr=%h expected 0000 00000040",
                     {s_busy, s_gnt1, s_en, s_we}, s_adr);
        end
        rv_seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            rv_seen += int'(s_rv0) + int'(s_rv1);
        end
        vectors++;
        if (rv_seen !== 0) begin
            miscompares++;
            $display("FAIL write_no_rvalid: got %0d rvalid pulses expected 0", rv_seen);
        end
    endtask

    task automatic test_tie();
        int      ngnt, nrv;
        logic    ep;
        rd_exp_t e;
        do_reset();
        sel = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
            ep = 1'b0;
`else
            ep = 1'(i % 2);
`endif
            gnt_q.push_back(ep);
            rd_q.push_back('{port: ep, data: ref_mem[ep ? 1 : 0]});
        end
        adr0 = 32'h0; adr1 = 32'h4; we0 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        ngnt = 0; nrv = 0;
        for (int k = 0; k < 60 && nrv < 4; k++) begin
            step();
            vectors++;
            if ((s_gnt0 && s_gnt1) || (s_rv0 && s_rv1)) begin
                miscompares++;
                $display("FAIL tie_exclusive: got gnt=%b%b rvalid=%b%b expected at most one each",
                         s_gnt0, s_gnt1, s_rv0, s_rv1);
            end
            if (s_gnt0 || s_gnt1) begin
                ngnt++;
                vectors++;
                if (gnt_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL tie_extra_gnt: got grant %0d expected none", ngnt);
                end else begin
                    ep = gnt_q.pop_front();
                    if (s_gnt1 !== ep) begin
                        miscompares++;
                        $display("FAIL tie_order: got port %b for grant %0d expected %b", s_gnt1, ngnt, ep);
                    end
                end
                if (ngnt == 4) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
            if ((s_rv0 || s_rv1) && rd_q.size() != 0) begin
                nrv++;
                e = rd_q.pop_front();
                vectors++;
                if ({s_rv1, s_rdata} !== {e.port, e.data}) begin
                    miscompares++;
                    $display("FAIL tie_rdata: got port=%b rdata=%h expected %b %h", s_rv1, s_rdata, e.port, e.data);
                end
            end
        end
        vectors++;
        if (nrv !== 4) begin
            miscompares++;
            $display("FAIL tie_done: got %0d reads completed expected 4", nrv);
        end
        req0 = 1'b0; req1 = 1'b0;
        gnt_q.delete();
        rd_q.delete();
        step();
    endtask

    task automatic test_latency_sweep(input int s);
        int      l, ng, nrv, cyc, gcyc, prv;
        rd_exp_t e;
        sel = s;
        l = lat_of(s);
        for (int i = 0; i < 4; i++) rd_q.push_back('{port: 1'b0, data: ref_mem[3 + i]});
        adr0 = 32'h0C; we0 = 1'b0; req0 = 1'b1;
        ng = 0; nrv = 0; cyc = 0; gcyc = 0; prv = -1;
        for (int k = 0; k < 60 && nrv < 4; k++) begin
            step();
            cyc++;
            if (s_gnt0) begin
                gcyc = cyc;
                ng++;
                if (ng < 4) adr0 = 32'h0C + 32'(4 * ng);
                else req0 = 1'b0;
            end
            if (s_rv0 && rd_q.size() != 0) begin
                nrv++;
                e = rd_q.pop_front();
                vectors++;
                if ({s_rdata, 32'(cyc - gcyc)} !== {e.data, 32'(l + 1)}) begin
                    miscompares++;
                    $display("FAIL lat%0d_read: got rdata=%h gnt-to-rvalid=%0d expected %h %0d",
                             l, s_rdata, cyc - gcyc, e.data, l + 1);
                end
                if (prv >= 0) begin
                    vectors++;
                    if (cyc - prv !== l + 2) begin
                        miscompares++;
                        $display("FAIL lat%0d_spacing: got %0d cycles expected %0d", l, cyc - prv, l + 2);
                    end
                end
                prv = cyc;
            end
        end
        vectors++;
        if (nrv !== 4) begin
            miscompares++;
            $display("FAIL lat%0d_done: got %0d reads expected 4", l, nrv);
        end
        req0 = 1'b0;
        rd_q.delete();
        step();
    endtask

    task automatic test_write_after_read();
        int      nrv;
        logic    ep;
        rd_exp_t e;
        do_reset();
        sel = 1;
        gnt_q.push_back(1'b0);
        gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0);
        rd_q.push_back('{port: 1'b0, data: ref_mem[2]});
        ref_mem[2] = 32'hA5A5A5A5;
        adr0 = 32'h8; we0 = 1'b0; req0 = 1'b1;
        adr1 = 32'h8; wd1 = 32'hA5A5A5A5; we1 = 1'b1; req1 = 1'b1;
        nrv = 0;
        for (int k = 0; k < 40 && nrv < 2; k++) begin
            step();
            if ((s_gnt0 || s_gnt1) && gnt_q.size() != 0) begin
                ep = gnt_q.pop_front();
                vectors++;
                if ({s_gnt0, s_gnt1} !== {~ep, ep}) begin
                    miscompares++;
                    $display("FAIL war_order: got gnt=%b%b expected port %b", s_gnt0, s_gnt1, ep);
                end
                if (s_gnt0) req0 = 1'b0;
                if (s_gnt1) begin
                    req1 = 1'b0; we1 = 1'b0;
                    rd_q.push_back('{port: 1'b0, data: ref_mem[2]});
                    req0 = 1'b1;
                end
            end
            if ((s_rv0 || s_rv1) && rd_q.size() != 0) begin
                nrv++;
                e = rd_q.pop_front();
                vectors++;
                if ({s_rv1, s_rdata} !== {e.port, e.data}) begin
                    miscompares++;
                    $display("FAIL war_rdata%0d: got port=%b rdata=%h expected %b %h",
                             nrv, s_rv1, s_rdata, e.port, e.data);
                end
            end
        end
        vectors++;
        if (nrv !== 2) begin
            miscompares++;
            $display("FAIL war_done: got %0d reads expected 2", nrv);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sel = 1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_tie();
        test_latency_sweep(0);
        test_latency_sweep(2);
        test_write_after_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
